// File: rtl/sad_accum_8bit.sv
// Sum-of-absolute-differences accumulator: collects N_SAMPLES a/b pairs into
// one SAD value, then holds it until the consumer acknowledges.
module sad_accum_8bit #(
  parameter int N_SAMPLES = 16,
  parameter int ACC_W     = 12
) (
  input  logic             clock,
  input  logic             reset_n,
  input  logic             start,
  input  logic [7:0]       a,
  input  logic [7:0]       b,
  input  logic             in_valid,
  output logic             in_ready,
  output logic [7:0]       diff,
  output logic [ACC_W-1:0] sad,
  output logic             sad_valid,
  input  logic             sad_ack,
  output logic             busy
);

  localparam int CNT_W = (N_SAMPLES > 1) ? $clog2(N_SAMPLES) : 1;
  localparam logic [CNT_W-1:0] LAST = CNT_W'(N_SAMPLES - 1);

  typedef enum logic [1:0] {IDLE, ACCUM, DONE} state_t;

  state_t           state, next_state;
  logic [CNT_W-1:0] count;
  logic             accept;
  logic [7:0]       abs_p0;

  // Borrow of the 9-bit a-b selects negation; exact 0..255, never saturates.
  function automatic logic [7:0] abs_diff(input logic [7:0] x, input logic [7:0] y);
    logic signed [8:0] d;
    d = $signed({1'b0, x}) - $signed({1'b0, y});
    if (d < 0) d = -d;
    return d[7:0];
  endfunction

  assign accept    = (state == ACCUM) && in_valid;
  assign abs_p0    = abs_diff(a, b);
  assign in_ready  = (state == ACCUM);
  assign busy      = (state == ACCUM) || (state == DONE);
  assign sad_valid = (state == DONE);

  always_ff @(posedge clock) begin
    if (!reset_n) state <= IDLE;
    else          state <= next_state;
  end

  always_comb begin
    next_state = state;
    case (state)
      IDLE:    if (start) next_state = ACCUM;
      ACCUM:   if (accept && count == LAST) next_state = DONE;
      DONE:    if (sad_ack) next_state = IDLE;
      default: next_state = IDLE;
    endcase
  end

  // Accumulation stage: a/b only matter on accepted cycles.
  always_ff @(posedge clock) begin
    if (!reset_n || (state == IDLE && start)) begin
      sad   <= '0;
      diff  <= '0;
      count <= '0;
    end else if (accept) begin
      sad   <= sad + ACC_W'(abs_p0);
      diff  <= abs_p0;
      count <= count + 1'b1;
    end
  end

endmodule

// File: tb/tb_sad_accum_8bit.sv
// Directed bench for sad_accum_8bit (N_SAMPLES=16, ACC_W=12) with
// hand-computed expected sums.
module tb_sad_accum_8bit;

  logic        clock = 1'b0;
  logic        reset_n;
  logic        start;
  logic [7:0]  a;
  logic [7:0]  b;
  logic        in_valid;
  logic        in_ready;
  logic [7:0]  diff;
  logic [11:0] sad;
  logic        sad_valid;
  logic        sad_ack;
  logic        busy;

  int checks = 0;
  int errors = 0;

  sad_accum_8bit #(.N_SAMPLES(16), .ACC_W(12)) dut (
    .clock(clock), .reset_n(reset_n), .start(start), .a(a), .b(b),
    .in_valid(in_valid), .in_ready(in_ready), .diff(diff), .sad(sad),
    .sad_valid(sad_valid), .sad_ack(sad_ack), .busy(busy)
  );

  always #5 clock = ~clock;

  task automatic step();
    @(posedge clock);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic pairs(input int n, input logic [7:0] av, input logic [7:0] bv);
    for (int i = 0; i < n; i++) begin
      a = av; b = bv; in_valid = 1'b1;
      step();
    end
    in_valid = 1'b0;
  endtask

  task automatic begin_block();
    start = 1'b1;
    step();
    start = 1'b0;
  endtask

  task automatic ack();
    sad_ack = 1'b1;
    step();
    sad_ack = 1'b0;
  endtask

  task automatic check_idle(input string tag, input logic [11:0] exp_sad);
    check({tag, "_in_ready"}, 32'(in_ready), 32'd0);
    check({tag, "_busy"}, 32'(busy), 32'd0);
    check({tag, "_sad_valid"}, 32'(sad_valid), 32'd0);
    check({tag, "_sad"}, 32'(sad), 32'(exp_sad));
  endtask

  initial begin
    reset_n = 1'b0; start = 1'b0; a = 8'd0; b = 8'd0; in_valid = 1'b0; sad_ack = 1'b0;
    step(); step();
    check_idle("reset", 12'd0);
    check("reset_diff", 32'(diff), 32'd0);

    // Stays idle after reset release, even with pairs and ack offered.
    reset_n = 1'b1; in_valid = 1'b1; a = 8'd5; b = 8'd1; sad_ack = 1'b1;
    step(); step();
    in_valid = 1'b0; sad_ack = 1'b0;
    check_idle("post_reset", 12'd0);

    // Block 1: 200-55 = 145, 16 pairs -> 2320; start pulsed mid-block.
    begin_block();
    check("b1_in_ready", 32'(in_ready), 32'd1);
    check("b1_busy", 32'(busy), 32'd1);
    check("b1_sad0", 32'(sad), 32'd0);
    pairs(4, 8'd200, 8'd55);
    start = 1'b1;
    pairs(2, 8'd200, 8'd55);
    start = 1'b0;
    check("b1_sad6", 32'(sad), 32'd870);
    check("b1_diff", 32'(diff), 32'd145);
    pairs(9, 8'd200, 8'd55);
    check("b1_sad15", 32'(sad), 32'd2175);
    check("b1_valid15", 32'(sad_valid), 32'd0);
    pairs(1, 8'd200, 8'd55);
    check("b1_valid", 32'(sad_valid), 32'd1);
    check("b1_sad", 32'(sad), 32'd2320);
    check("b1_done_ready", 32'(in_ready), 32'd0);
    check("b1_done_busy", 32'(busy), 32'd1);

    // DONE holds against start and offered pairs.
    start = 1'b1; in_valid = 1'b1; a = 8'd0; b = 8'd255;
    step(); step();
    in_valid = 1'b0;
    check("b1_hold_valid", 32'(sad_valid), 32'd1);
    check("b1_hold_sad", 32'(sad), 32'd2320);
    check("b1_hold_diff", 32'(diff), 32'd145);
    // start together with ack: ack wins, start ignored.
    ack();
    start = 1'b0;
    check_idle("b1_ack", 12'd2320);
    step();
    check_idle("b1_idle_again", 12'd2320);

    // Block 2: |10-250| = 240 -> 3840; ack ignored during ACCUM.
    begin_block();
    check("b2_cleared", 32'(sad), 32'd0);
    sad_ack = 1'b1;
    pairs(8, 8'd10, 8'd250);
    sad_ack = 1'b0;
    check("b2_ack_ignored", 32'(in_ready), 32'd1);
    check("b2_sad8", 32'(sad), 32'd1920);
    pairs(8, 8'd10, 8'd250);
    check("b2_valid", 32'(sad_valid), 32'd1);
    check("b2_sad", 32'(sad), 32'd3840);
    check("b2_diff", 32'(diff), 32'd240);
    ack();

    // Block 3: 255-0 -> 4080, no wrap in 12 bits.
    begin_block();
    pairs(16, 8'd255, 8'd0);
    check("b3_sad", 32'(sad), 32'd4080);
    check("b3_diff", 32'(diff), 32'd255);
    ack();

    // Block 4: a=b=77 with junk on the idle cycles in between.
    begin_block();
    for (int i = 0; i < 16; i++) begin
      a = 8'd77; b = 8'd77; in_valid = 1'b1;
      step();
      if (i < 15) begin
        a = 8'd0; b = 8'd255; in_valid = 1'b0;
        step();
      end
    end
    in_valid = 1'b0;
    check("b4_sad", 32'(sad), 32'd0);
    check("b4_diff", 32'(diff), 32'd0);
    check("b4_valid", 32'(sad_valid), 32'd1);
    ack();
    // Same pattern, but check sad_valid is low just before the 16th acceptance.
    begin_block();
    for (int i = 0; i < 15; i++) begin
      a = 8'd77; b = 8'd76; in_valid = 1'b1;
      step();
      in_valid = 1'b0;
      step();
    end
    check("b4b_not_yet", 32'(sad_valid), 32'd0);
    check("b4b_sad15", 32'(sad), 32'd15);
    pairs(1, 8'd76, 8'd77);
    check("b4b_sad", 32'(sad), 32'd16);
    ack();

    // Block 5: reset after 5 pairs of 9,3 discards the partial sum.
    begin_block();
    pairs(5, 8'd9, 8'd3);
    check("b5_partial", 32'(sad), 32'd30);
    reset_n = 1'b0; in_valid = 1'b1; start = 1'b1;
    step();
    reset_n = 1'b1; in_valid = 1'b0; start = 1'b0;
    check_idle("b5_reset", 12'd0);
    check("b5_reset_diff", 32'(diff), 32'd0);
    begin_block();
    pairs(16, 8'd9, 8'd3);
    check("b5_sad", 32'(sad), 32'd96);
    check("b5_valid", 32'(sad_valid), 32'd1);

    // Reset in DONE discards the final sum.
    reset_n = 1'b0;
    step();
    reset_n = 1'b1;
    check_idle("done_reset", 12'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/sad_accum_8bit.md
SAD_ACCUM_8BIT -- requirements
Module: sad_accum_8bit

Interface
REQ-001 SHALL have parameter N_SAMPLES, default 16, the number of sample pairs per SAD block (2..256).
REQ-002 SHALL have parameter ACC_W, default 12, the accumulator width; must be >= 8 + clog2(N_SAMPLES).
REQ-003 SHALL have port clock  input  1  rising-edge clock.
REQ-004 SHALL have port reset_n  input  1  reset, synchronous, active-low.
REQ-005 SHALL have port start  input  1  begin a new SAD block; honoured only in IDLE.
REQ-006 SHALL have port a  input  8  unsigned sample A.
REQ-007 SHALL have port b  input  8  unsigned sample B.
REQ-008 SHALL have port in_valid  input  1  a/b pair valid.
REQ-009 SHALL have port in_ready  output  1  block accepts a pair this cycle.
REQ-010 SHALL have port diff  output  8  registered |a-b| of the last accepted pair.
REQ-011 SHALL have port sad  output  ACC_W  accumulated sum of absolute differences.
REQ-012 SHALL have port sad_valid  output  1  sad is final and held.
REQ-013 SHALL have port sad_ack  input  1  consumer has taken sad.
REQ-014 SHALL have port busy  output  1  high in ACCUM and DONE.

Function
REQ-015 SHALL implement FSM states IDLE, ACCUM, DONE; all outputs are registered or decoded from state only.
REQ-016 IDLE: in_ready=0, busy=0, sad_valid=0; start=1 -> next cycle ACCUM, sad=0, diff=0, count=0.
REQ-017 ACCUM: in_ready=1, busy=1; a pair is accepted on a cycle with in_valid=1 and in_ready=1; cycles with in_valid=0 leave sad, diff and count unchanged.
REQ-018 On acceptance: diff <= |a-b|, sad <= sad + |a-b|, count <= count+1, all at the same clock edge.
REQ-019 |a-b| SHALL be computed as the 9-bit difference a-b, negated when the borrow bit is set; the result is 0..255 exact, with no saturation.
REQ-020 sad arithmetic is unsigned ACC_W-bit; with a legal ACC_W it never overflows; with an illegal ACC_W it wraps modulo 2^ACC_W.
REQ-021 The acceptance with count = N_SAMPLES-1 SHALL move to DONE; sad_valid=1 in the very next cycle with the final sum (latency 1 cycle after the last accepted pair).
REQ-022 DONE: in_ready=0, busy=1, sad_valid=1, sad and diff held stable; sad_ack=1 -> IDLE next cycle (sad_valid=0, sad retains its value until the next start).
REQ-023 start SHALL be ignored in ACCUM and DONE, including start and sad_ack asserted together in DONE; a new block then requires start in IDLE.
REQ-024 sad_ack SHALL be ignored outside DONE.
REQ-025 a/b SHALL be sampled only on accepted cycles; values on other cycles have no effect.

Reset
REQ-026 reset_n=0 at a rising edge SHALL force IDLE, sad=0, diff=0, count=0, sad_valid=0, busy=0, in_ready=0, overriding all other inputs.
REQ-027 Reset asserted mid-ACCUM or in DONE SHALL discard the partial or final sum; there is no carry-over into the next block.
REQ-028 After reset deassertion the block SHALL stay in IDLE until start.

Verification
REQ-029 N=16, start, then 16 back-to-back pairs a=200,b=55 -> diff=145; sad_valid rises 1 cycle after the 16th pair; sad=2320.
REQ-030 N=16, 16 pairs a=10,b=250 -> diff=240, sad=3840; 16 pairs a=255,b=0 -> sad=4080, no wrap in 12 bits.
REQ-031 N=16, 16 pairs with a=b=77, with in_valid low on alternate cycles -> sad=0, sad_valid only after the 16th accepted pair; idle cycles do not count.
REQ-032 Reset after 5 accepted pairs (a=9,b=3) -> next cycle IDLE, sad=0, in_ready=0; a new start plus 16 pairs of a=9,b=3 -> sad=96.
REQ-033 start pulsed during ACCUM and during DONE -> no clearing, sad unchanged; sad_ack in DONE -> IDLE, sad_valid=0, sad retains 2320.
